// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state encoding and the step-counter width helper.
package exe_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

  localparam int MD_DEFAULT_WIDTH = 32;
  localparam int MD_DEFAULT_CNT_W = $clog2(MD_DEFAULT_WIDTH);

  // Width of the per-bit step counter for a given operand width.
  function automatic int md_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Request/response bundle between the decode stage and exe_muldiv.
interface exe_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] Rd1;
  logic [WIDTH-1:0] Rd2;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] md_result;

  modport master (
    output start, md_op, Rd1, Rd2, kill,
    input  busy, done, md_result
  );

  modport slave (
    input  start, md_op, Rd1, Rd2, kill,
    output busy, done, md_result
  );
endinterface

// File: rtl/exe_muldiv_md_sign.sv
// md_sign: sign extraction / conditional two's-complement negation.
// On entry (sgn_en=1, flip=0) it yields |din| and the sign flag; on exit
// (sgn_en=0) it negates din when flip is set.
module md_sign #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         sgn_en,
  input  logic         flip,
  output logic [W-1:0] dout,
  output logic         sign
);
  assign sign = sgn_en & din[W-1];
  assign dout = (sign ^ flip) ? (-din) : din;
endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative RV32M multiply/divide unit (shift-add multiply,
// restoring divide, one bit per cycle). Define EXE_MULDIV_FAST_MUL_EN to
// replace the iterative multiply with a single-cycle combinational one.
module exe_muldiv
  import exe_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rstn,
  exe_muldiv_if.slave bus
);
  localparam int CW = md_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e            state_reg, state_next;
  logic [CW-1:0]        cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg, acc_step;
  logic [WIDTH-1:0]     opnd_reg;
  logic [2:0]           op_reg;
  logic                 sa_reg, sb_reg, busy_reg, done_reg;
  logic [WIDTH-1:0]     res_reg, res_next;

  // Incoming request decode
  logic [2:0]       op_in;
  logic             is_div_in, div0_in, ovf_in, fast_in, accept;
  logic [1:0]       sgn_en_in, sgn_in;
  logic [WIDTH-1:0] opnd_raw [2];
  logic [WIDTH-1:0] mag_in [2];
  logic [WIDTH-1:0] special_res;

  assign op_in        = bus.md_op;
  assign is_div_in    = op_in[2];
  assign sgn_en_in[0] = is_div_in ? ~op_in[0] : (op_in != OP_MULHU);
  assign sgn_en_in[1] = is_div_in ? ~op_in[0] : ~op_in[1];
  assign opnd_raw[0]  = bus.Rd1;
  assign opnd_raw[1]  = bus.Rd2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      md_sign #(.W(WIDTH)) u_sign (
        .din(opnd_raw[gi]), .sgn_en(sgn_en_in[gi]), .flip(1'b0),
        .dout(mag_in[gi]), .sign(sgn_in[gi])
      );
    end
  endgenerate

  assign div0_in = is_div_in && (bus.Rd2 == '0);
  assign ovf_in  = is_div_in && !op_in[0] && (bus.Rd1 == MIN_NEG) && (bus.Rd2 == '1);
  assign special_res = div0_in ? (op_in[1] ? bus.Rd1 : '1) : (op_in[1] ? '0 : MIN_NEG);
`ifdef EXE_MULDIV_FAST_MUL_EN
  assign fast_in = ~is_div_in;
`else
  assign fast_in = 1'b0;
`endif
  assign accept = (state_reg == ST_IDLE) && bus.start && !bus.kill;

  // One iteration: multiply adds the multiplicand into the high half and
  // shifts right; divide shifts left and keeps the trial subtraction if it
  // does not borrow (hi = partial remainder, lo = dividend/quotient bits).
  logic [WIDTH:0] mul_sum, div_trial, div_diff;
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    div_trial = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, opnd_reg};
    if (op_reg[2]) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      else                  acc_step = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

  // Select what the sign-fix stage works on: the last iteration result, or
  // in IDLE the live request (only used by the single-cycle multiply path).
  logic [2*WIDTH-1:0] fin_val, prod_fix;
  logic [2:0]         fin_op;
  logic               fin_sa, fin_sb;
  logic [WIDTH-1:0]   quo_fix, rem_fix, calc_res;
  logic [2:0]         unused_sign;
  always_comb begin
    fin_val = acc_step;
    fin_op  = op_reg;
    fin_sa  = sa_reg;
    fin_sb  = sb_reg;
    if (state_reg == ST_IDLE) begin
      fin_op = op_in;
      fin_sa = sgn_in[0];
      fin_sb = sgn_in[1];
`ifdef EXE_MULDIV_FAST_MUL_EN
      fin_val = mag_in[0] * mag_in[1];
`endif
    end
  end

  md_sign #(.W(2*WIDTH)) u_prod_sign (
    .din(fin_val), .sgn_en(1'b0), .flip(fin_sa ^ fin_sb),
    .dout(prod_fix), .sign(unused_sign[0])
  );
  md_sign #(.W(WIDTH)) u_quo_sign (
    .din(fin_val[WIDTH-1:0]), .sgn_en(1'b0), .flip(fin_sa ^ fin_sb),
    .dout(quo_fix), .sign(unused_sign[1])
  );
  md_sign #(.W(WIDTH)) u_rem_sign (
    .din(fin_val[2*WIDTH-1:WIDTH]), .sgn_en(1'b0), .flip(fin_sa),
    .dout(rem_fix), .sign(unused_sign[2])
  );

  assign calc_res = fin_op[2] ? (fin_op[1] ? rem_fix : quo_fix)
                              : ((fin_op == OP_MUL) ? prod_fix[WIDTH-1:0]
                                                    : prod_fix[2*WIDTH-1:WIDTH]);
  assign res_next = ((state_reg == ST_IDLE) && (div0_in || ovf_in)) ? special_res : calc_res;

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = (div0_in || ovf_in || fast_in) ? ST_FIN : ST_CALC;
      ST_CALC: if (cnt_reg == CW'(WIDTH-1)) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (bus.kill) state_next = ST_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Operand capture on accept, then one iteration per CALC cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      opnd_reg <= '0;
      op_reg   <= '0;
      sa_reg   <= 1'b0;
      sb_reg   <= 1'b0;
    end else if (accept) begin
      op_reg  <= op_in;
      sa_reg  <= sgn_in[0];
      sb_reg  <= sgn_in[1];
      cnt_reg <= '0;
      if (is_div_in) begin
        opnd_reg <= mag_in[1];
        acc_reg  <= {{WIDTH{1'b0}}, mag_in[0]};
      end else begin
        opnd_reg <= mag_in[0];
        acc_reg  <= {{WIDTH{1'b0}}, mag_in[1]};
      end
    end else if (state_reg == ST_CALC) begin
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Registered outputs: result and done are loaded on the way into FIN, so a
  // kill on that transition drops both and leaves md_result untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      res_reg  <= '0;
    end else begin
      busy_reg <= (state_next != ST_IDLE);
      done_reg <= (state_next == ST_FIN);
      if (state_next == ST_FIN) res_reg <= res_next;
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.md_result = res_reg;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv (WIDTH = 32) with a 64-bit arithmetic
// reference model. Honours EXE_MULDIV_FAST_MUL_EN for multiply latency.
module tb_exe_muldiv;
  import exe_muldiv_pkg::*;

  localparam int W = 32;
`ifdef EXE_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc_cnt = 0;

  exe_muldiv_if #(.WIDTH(W)) bus ();
  exe_muldiv #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: RISC-V M semantics with wide arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64;
    logic [63:0] ua64, ub64, p;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (op)
      OP_MUL:    begin p = ua64 * ub64; return p[31:0]; end
      OP_MULH:   begin p = sa64 * sb64; return p[63:32]; end
      OP_MULHSU: begin p = sa64 * $signed(ub64); return p[63:32]; end
      OP_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return $signed(a) / $signed(b);
      end
      OP_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  // Issue one op at the current negedge and follow it to done.
  // perr counts cycles where busy was wrong or done did not drop after one cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int dcyc, output int perr);
    int cyc;
    bus.start = 1'b1; bus.md_op = op; bus.Rd1 = a; bus.Rd2 = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; dcyc = -1; perr = 0; res = '0;
    while (dcyc < 0 && cyc <= 3*W) begin
      if (bus.busy !== 1'b1) perr++;
      if (bus.done === 1'b1) begin dcyc = cyc; res = bus.md_result; end
      @(negedge clk); cyc++;
    end
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) perr++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b expected 0", bus.done); end
    n_vec++; if (bus.md_result !== 32'd0) begin n_bad++; $display("FAIL reset md_result: got %h expected 0", bus.md_result); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    logic [31:0] av  [4] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev  [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int dcyc, perr;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], res, dcyc, perr);
      $display("mul op=%0d a=%h b=%h -> %h @cycle %0d", ops[i], av[i], bv[i], res, dcyc);
      n_vec++; if (res !== ev[i]) begin n_bad++; $display("FAIL mul[%0d] result: got %h expected %h", i, res, ev[i]); end
      n_vec++; if (dcyc !== MUL_LAT) begin n_bad++; $display("FAIL mul[%0d] done cycle: got %0d expected %0d", i, dcyc, MUL_LAT); end
      n_vec++; if (perr !== 0) begin n_bad++; $display("FAIL mul[%0d] busy/done shape: got %0d bad cycles expected 0", i, perr); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [8] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] av  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'd5, MIN_NEG, MIN_NEG};
    logic [31:0] bv  [8] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'hFFFF_FFFF, 32'd5, MIN_NEG, 32'd0};
    int          lv  [8] = '{DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT, 1, 1, 1, 1};
    logic [31:0] res;
    int dcyc, perr;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], av[i], bv[i], res, dcyc, perr);
      $display("div op=%0d a=%h b=%h -> %h @cycle %0d", ops[i], av[i], bv[i], res, dcyc);
      n_vec++; if (res !== ev[i]) begin n_bad++; $display("FAIL div[%0d] result: got %h expected %h", i, res, ev[i]); end
      n_vec++; if (dcyc !== lv[i]) begin n_bad++; $display("FAIL div[%0d] done cycle: got %0d expected %0d", i, dcyc, lv[i]); end
      n_vec++; if (perr !== 0) begin n_bad++; $display("FAIL div[%0d] busy/done shape: got %0d bad cycles expected 0", i, perr); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, res;
    int dcyc, perr, t_prev;
    t_prev = cyc_cnt;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom | 32'd1;
      run_op(OP_DIVU, a, b, res, dcyc, perr);
      $display("b2b DIVU a=%h b=%h -> %h @cycle %0d", a, b, res, dcyc);
      n_vec++; if (res !== ref_md(OP_DIVU, a, b)) begin n_bad++; $display("FAIL b2b[%0d] result: got %h expected %h", i, res, ref_md(OP_DIVU, a, b)); end
      n_vec++; if (cyc_cnt - t_prev !== W + 2) begin n_bad++; $display("FAIL b2b[%0d] issue interval: got %0d expected %0d", i, cyc_cnt - t_prev, W + 2); end
      t_prev = cyc_cnt;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res, exp;
    int dcyc, perr, sel;
    for (int i = 0; i < 48; i++) begin
      op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
      if (sel == 2) begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
      if (sel == 3) a = -32'($urandom_range(1, 100));
      exp = ref_md(op, a, b);
      run_op(op, a, b, res, dcyc, perr);
      $display("rnd[%0d] op=%0d a=%h b=%h -> %h @cycle %0d", i, op, a, b, res, dcyc);
      n_vec++; if (res !== exp) begin n_bad++; $display("FAIL rnd[%0d] result: got %h expected %h", i, res, exp); end
      n_vec++; if (dcyc !== exp_lat(op, a, b)) begin n_bad++; $display("FAIL rnd[%0d] done cycle: got %0d expected %0d", i, dcyc, exp_lat(op, a, b)); end
      n_vec++; if (perr !== 0) begin n_bad++; $display("FAIL rnd[%0d] busy/done shape: got %0d bad cycles expected 0", i, perr); end
    end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int dcyc, perr, cyc, ndone;
    run_op(OP_DIVU, 32'd100, 32'd7, res, dcyc, perr);
    n_vec++; if (res !== 32'd14) begin n_bad++; $display("FAIL kill setup result: got %h expected %h", res, 32'd14); end
    bus.start = 1'b1; bus.md_op = OP_DIVU; bus.Rd1 = $urandom; bus.Rd2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; ndone = 0;
    while (cyc < 10) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk); cyc++;
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    $display("kill DIVU at cycle 10 -> busy=%b in cycle 11", bus.busy);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill busy cycle 11: got %b expected 0", bus.busy); end
    repeat (3*W) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_vec++; if (ndone !== 0) begin n_bad++; $display("FAIL kill done pulses: got %0d expected 0", ndone); end
    n_vec++; if (bus.md_result !== 32'd14) begin n_bad++; $display("FAIL kill md_result held: got %h expected %h", bus.md_result, 32'd14); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] res;
    int cyc, dcyc, nextra;
    bus.start = 1'b1; bus.md_op = OP_DIVU; bus.Rd1 = 32'hFFFF_FFFF; bus.Rd2 = 32'd3;
    @(negedge clk);
    cyc = 1; dcyc = -1; res = '0;
    while (dcyc < 0 && cyc <= 3*W) begin
      bus.start = (cyc == 5);
      if (cyc == 5) begin bus.md_op = OP_DIV; bus.Rd1 = 32'd5; bus.Rd2 = 32'd0; end
      if (bus.done === 1'b1) begin dcyc = cyc; res = bus.md_result; end
      @(negedge clk); cyc++;
    end
    bus.start = 1'b0;
    $display("start-while-busy DIVU -> %h @cycle %0d", res, dcyc);
    n_vec++; if (res !== 32'h5555_5555) begin n_bad++; $display("FAIL ignore-start result: got %h expected %h", res, 32'h5555_5555); end
    n_vec++; if (dcyc !== DIV_LAT) begin n_bad++; $display("FAIL ignore-start done cycle: got %0d expected %0d", dcyc, DIV_LAT); end
    nextra = 0;
    repeat (2*W) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nextra++;
      @(negedge clk);
    end
    n_vec++; if (nextra !== 0) begin n_bad++; $display("FAIL ignore-start extra activity: got %0d cycles expected 0", nextra); end
  endtask

  task automatic test_kill_start();
    int nact;
    bus.start = 1'b1; bus.kill = 1'b1; bus.md_op = OP_DIVU; bus.Rd1 = 32'd9; bus.Rd2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    $display("kill+start in IDLE -> busy=%b", bus.busy);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill+start busy: got %b expected 0", bus.busy); end
    nact = 0;
    repeat (2*W) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) nact++;
      @(negedge clk);
    end
    n_vec++; if (nact !== 0) begin n_bad++; $display("FAIL kill+start activity: got %0d cycles expected 0", nact); end
    n_vec++; if (bus.md_result !== 32'h5555_5555) begin n_bad++; $display("FAIL kill+start md_result: got %h expected %h", bus.md_result, 32'h5555_5555); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int dcyc, perr;
    bus.start = 1'b1; bus.md_op = OP_MUL; bus.Rd1 = 32'h0001_2345; bus.Rd2 = 32'h0000_0777;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    $display("reset at cycle 20: busy=%b done=%b md_result=%h", bus.busy, bus.done, bus.md_result);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL async reset busy: got %b expected 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL async reset done: got %b expected 0", bus.done); end
    n_vec++; if (bus.md_result !== 32'd0) begin n_bad++; $display("FAIL async reset md_result: got %h expected 0", bus.md_result); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_op(OP_MUL, 32'd3, 32'd4, res, dcyc, perr);
    $display("post-reset MUL 3*4 -> %h @cycle %0d", res, dcyc);
    n_vec++; if (res !== 32'd12) begin n_bad++; $display("FAIL post-reset result: got %h expected %h", res, 32'd12); end
    n_vec++; if (dcyc !== MUL_LAT) begin n_bad++; $display("FAIL post-reset done cycle: got %0d expected %0d", dcyc, MUL_LAT); end
  endtask

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.md_op = 3'd0; bus.Rd1 = '0; bus.Rd2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_random();
    test_kill();
    test_start_ignored();
    test_kill_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative RV32M multiply/divide execution unit, parametrised in operand width. It sits beside the single-cycle `exe` ALU and takes the same `Rd1`/`Rd2` operands when the decoder flags an M-extension instruction. The pipeline stalls on `busy` until the one-cycle `done` pulse. Results follow RISC-V M semantics, including the divide-by-zero and signed-overflow cases.

## Interface
- `WIDTH`, default 32: operand and result width; must be even and ≥ 8.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `md_op` in 3: funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `Rd1` in WIDTH: operand a (multiplicand / dividend).
- `Rd2` in WIDTH: operand b (multiplier / divisor).
- `kill` in 1: abort (flush/trap); synchronous.
- `busy` out 1: registered; high whenever state ≠ IDLE.
- `done` out 1: registered one-cycle pulse; `md_result` valid.
- `md_result` out WIDTH: registered result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE + `start` + !`kill`: latch `md_op`, sign flags and operand magnitudes.
  - Signed ops: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats a as signed, b as unsigned.
  - Divisor == 0, or signed overflow (a = 2^(W-1)·-1 pattern 0x80…0 with b = all-ones, DIV/REM only): go to FIN with the special result.
  - Otherwise go to CALC with `cnt` = 0.
- CALC, multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle.
- CALC exit: after `cnt` reaches WIDTH-1, go to FIN.
- FIN:
  - Multiply sign fix: negate the 2W product if sa^sb.
  - Divide sign fix: quotient negated if sa^sb; remainder takes the sign of a.
  - Select low half (MUL) or high half (MULH*) of the product, or quotient/remainder.
  - Register into `md_result`, pulse `done`, return to IDLE.
- Special results:
  - Divide by zero: DIV/DIVU = all-ones; REM/REMU = a.
  - Overflow: DIV = 0x80…0; REM = 0.
- `start` while busy: ignored; no queueing.
- `kill` in any state: next state IDLE; no `done`; `md_result` unchanged.
- `kill` together with `start` in IDLE: `kill` wins and the request is dropped.
- `kill` in FIN: `done` is suppressed.
- Reset, asynchronous, at any point including mid-operation: state IDLE, `cnt` 0, `busy` 0, `done` 0, `md_result` 0, internal accumulators 0.

## Timing
- Start cycle is 0 (`start` high, state IDLE).
- Normal op: CALC in cycles 1..WIDTH; FIN in cycle WIDTH+1.
  - `done` = 1 and `md_result` valid in cycle WIDTH+1 (cycle 33 for WIDTH = 32).
- Special div case: FIN in cycle 1; `done` in cycle 1.
- `busy` is high in cycles 1 through (`done` cycle) inclusive, and low the cycle after.
- Back-to-back: a new `start` is accepted in the cycle after `done`. Minimum issue interval is WIDTH+2 cycles.
- `kill` high in cycle k: state IDLE and `busy` 0 in cycle k+1.

## Configuration
- `EXE_MULDIV_FAST_MUL_EN`.
  - Defined: the four multiply ops use a combinational WIDTH×WIDTH multiplier and go IDLE→FIN directly, so `done` arrives in cycle 1. Divide timing is unchanged.
  - Undefined: all multiply ops are iterative with WIDTH+1 cycle latency, and no hardware multiplier is inferred.

## Structure
- Shared package `exe_muldiv_pkg`: `md_op` encodings as localparams, state encoding (IDLE/CALC/FIN), and a helper constant for the `cnt` width ($clog2(WIDTH)).
- One sub-module: `md_sign`, a combinational block that computes absolute values and sign flags on entry and the conditional negation on exit. It is reused for both operands and the result.
- Everything else (FSM, counter, iterative datapath, output registers) lives in `exe_muldiv`.

## Test plan
- MUL, a = 7, b = 0xFFFFFFFD: `done` in cycle 33 with `md_result` 0xFFFFFFEB. MULH on the same operands gives 0xFFFFFFFF. `busy` is high in cycles 1–33.
- MULHU, a = b = 0xFFFFFFFF: result 0xFFFFFFFE. MULHSU on the same operands gives 0xFFFFFFFF. With `EXE_MULDIV_FAST_MUL_EN`, the same results arrive in cycle 1.
- DIV, a = 0xFFFFFFF9 (-7), b = 2: result 0xFFFFFFFD. REM on the same operands gives 0xFFFFFFFF. DIVU, a = 7, b = 2, gives 3. REMU, a = 7, b = 2, gives 1.
- DIV, a = 5, b = 0: 0xFFFFFFFF with `done` in cycle 1. REMU, a = 5, b = 0: 5. DIV, a = 0x80000000, b = 0xFFFFFFFF: 0x80000000. REM on the same operands gives 0.
- `kill` in cycle 10 of a DIVU: no `done`, `busy` low in cycle 11, `md_result` keeps its prior value. A `start` pulsed in cycle 5 of an op is ignored. `kill` and `start` together in IDLE: no `busy`.
- `rstn` asserted in cycle 20 of a MUL: `busy`, `done` and `md_result` go to 0 immediately. After release, a fresh MUL 3×4 gives 12 in cycle 33 post-start.
